// File: rtl/branch_predictor_btb_if.sv
// Fetch/execute connection of the next-PC predictor.
// master = pipeline side, slave = predictor.
interface branch_predictor_btb_if #(
    parameter int WIDTH = 32
);
    // F stage
    logic [WIDTH-1:0] PCF;
    logic             PredTakenF;
    logic [WIDTH-1:0] PredTargetF;
    logic [WIDTH-1:0] NextPCF;
    // E stage
    logic [WIDTH-1:0] PCE;
    logic             BranchE;
    logic             JumpE;
    logic             TakenE;
    logic [WIDTH-1:0] TargetE;
    logic             PredTakenE;
    logic [WIDTH-1:0] PredTargetE;
    logic             MispredictE;
    logic [WIDTH-1:0] RedirectPCE;
    // statistics
    logic [31:0]      BranchCount;
    logic [31:0]      MispredCount;

    modport master (
        output PCF, PCE, BranchE, JumpE, TakenE, TargetE, PredTakenE, PredTargetE,
        input  PredTakenF, PredTargetF, NextPCF, MispredictE, RedirectPCE,
               BranchCount, MispredCount
    );

    modport slave (
        input  PCF, PCE, BranchE, JumpE, TakenE, TargetE, PredTakenE, PredTargetE,
        output PredTakenF, PredTargetF, NextPCF, MispredictE, RedirectPCE,
               BranchCount, MispredCount
    );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit counters: predicts the next fetch PC in F,
// detects mispredicts in E, supplies the redirect PC and trains on resolution.
module branch_predictor_btb #(
    parameter  int WIDTH      = 32,
    parameter  int ENTRIES    = 16,
    localparam int INDEX_BITS = $clog2(ENTRIES)
) (
    input logic                    clk,
    input logic                    rst,
    branch_predictor_btb_if.slave  bus
);
    localparam int TAG_BITS = WIDTH - INDEX_BITS - 2;

    // BTB storage
    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [WIDTH-1:0]    target_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];
    logic                jmp_q    [ENTRIES];

    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    // F lookup port
    logic [INDEX_BITS-1:0] f_idx;
    logic [TAG_BITS-1:0]   f_tag;
    logic                  f_hit;
    logic                  pred_taken_f;

    // E read/update port
    logic [INDEX_BITS-1:0] e_idx;
    logic [TAG_BITS-1:0]   e_tag;
    logic                  e_hit;
    logic                  resolve;
    logic                  mispredict;
    logic [WIDTH-1:0]      redirect_pc;

    logic                  wr_en;
    logic                  wr_valid;
    logic [WIDTH-1:0]      wr_target;
    logic [1:0]            wr_ctr;
    logic                  wr_jmp;

    // Word-offset bits never take part in indexing.
    logic unused_lsbs;
    assign unused_lsbs = ^{bus.PCF[1:0], bus.PCE[1:0]};

    assign f_idx = bus.PCF[INDEX_BITS+1:2];
    assign f_tag = bus.PCF[WIDTH-1:INDEX_BITS+2];
    assign e_idx = bus.PCE[INDEX_BITS+1:2];
    assign e_tag = bus.PCE[WIDTH-1:INDEX_BITS+2];

    // F prediction and next-PC select; mispredict redirect has priority
    always_comb begin
        f_hit        = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        pred_taken_f = f_hit && (jmp_q[f_idx] || ctr_q[f_idx][1]);
        bus.PredTakenF  = pred_taken_f;
        bus.PredTargetF = pred_taken_f ? target_q[f_idx] : '0;
        if (mispredict) begin
            bus.NextPCF = redirect_pc;
        end else if (pred_taken_f) begin
            bus.NextPCF = target_q[f_idx];
        end else begin
            bus.NextPCF = bus.PCF + WIDTH'(4);
        end
    end

    // E resolution: mispredict detection and correct next PC
    always_comb begin
        resolve     = bus.BranchE | bus.JumpE;
        redirect_pc = bus.TakenE ? bus.TargetE : bus.PCE + WIDTH'(4);
        if (resolve) begin
            mispredict = (bus.PredTakenE != bus.TakenE) ||
                         (bus.TakenE && (bus.PredTargetE != bus.TargetE));
        end else begin
            mispredict = bus.PredTakenE;
        end
        bus.MispredictE = mispredict;
        bus.RedirectPCE = redirect_pc;
    end

    // E training decision: train on hit, allocate on taken miss, drop a bogus prediction
    always_comb begin
        e_hit     = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
        wr_en     = 1'b0;
        wr_valid  = 1'b1;
        wr_target = target_q[e_idx];
        wr_ctr    = ctr_q[e_idx];
        wr_jmp    = jmp_q[e_idx];
        if (resolve) begin
            if (e_hit) begin
                wr_en  = 1'b1;
                wr_jmp = bus.JumpE;
                if (bus.TakenE) begin
                    wr_target = bus.TargetE;
                    wr_ctr    = (ctr_q[e_idx] == 2'b11) ? 2'b11 : ctr_q[e_idx] + 2'd1;
                end else begin
                    wr_ctr    = (ctr_q[e_idx] == 2'b00) ? 2'b00 : ctr_q[e_idx] - 2'd1;
                end
            end else if (bus.TakenE) begin
                wr_en     = 1'b1;
                wr_target = bus.TargetE;
                wr_jmp    = bus.JumpE;
                wr_ctr    = bus.JumpE ? 2'b11 : 2'b10;
            end
        end else if (bus.PredTakenE && e_hit) begin
            wr_en    = 1'b1;
            wr_valid = 1'b0;
        end
    end

    // BTB write; reset wins over a coincident update
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
                jmp_q[i]    <= 1'b0;
            end
        end else if (wr_en) begin
            valid_q[e_idx]  <= wr_valid;
            tag_q[e_idx]    <= e_tag;
            target_q[e_idx] <= wr_target;
            ctr_q[e_idx]    <= wr_ctr;
            jmp_q[e_idx]    <= wr_jmp;
        end
    end

    // Saturating statistics next-state
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (resolve && (branch_cnt_q != '1)) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
        end
        if (mispredict && (mispred_cnt_q != '1)) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign bus.BranchCount  = branch_cnt_q;
    assign bus.MispredCount = mispred_cnt_q;
endmodule
